// File: rtl/axilite_pkg.sv
// Shared definitions for the AXI4-Lite CSR bank.
// Contents: response codes, write/read FSM state types, and the word-index
// region decoder that maps a word index onto the RW/RO/TRIG/unmapped ranges.
package axilite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_RESP}         rd_state_t;

  typedef enum logic [1:0] {REG_RW, REG_RO, REG_TRIG, REG_UNMAPPED} region_t;

  typedef struct packed {
    region_t     region;
    logic [31:0] idx;     // index local to the region
  } decode_t;

  // Regions are laid out back to back: RW first, then RO, then TRIG.
  function automatic decode_t decode_word(input logic [31:0] word,
                                          input int unsigned num_rw,
                                          input int unsigned num_ro,
                                          input int unsigned num_trig);
    decode_t d;
    d.region = REG_UNMAPPED;
    d.idx    = '0;
    if (word < num_rw) begin
      d.region = REG_RW;
      d.idx    = word;
    end else if (word < num_rw + num_ro) begin
      d.region = REG_RO;
      d.idx    = word - num_rw;
    end else if (word < num_rw + num_ro + num_trig) begin
      d.region = REG_TRIG;
      d.idx    = word - num_rw - num_ro;
    end
    return d;
  endfunction

endpackage

// File: rtl/axilite_slave_if.sv
// AXI4-Lite slave handshake engine: owns the write and read FSMs.
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   cbus_aw*/w*/b*        write address, data and response channels
//   cbus_ar*/r*           read address and data channels
//   wr_en/wr_idx/wr_data/wr_strb  single-cycle write strobe to the bank
//   wr_err                bank flags the pending write as illegal
//   rd_en/rd_idx          read request (valid in the AR handshake cycle)
//   rd_data/rd_err        bank read result for rd_idx, same cycle
module axilite_slave_if
  import axilite_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned ADDR_W = 8,
  localparam int unsigned STRB_W = DATA_W / 8,
  localparam int unsigned OFF_W  = $clog2(STRB_W),
  localparam int unsigned IDX_W  = ADDR_W - OFF_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] cbus_awaddr,
  input  logic              cbus_awvalid,
  output logic              cbus_awready,
  input  logic [DATA_W-1:0] cbus_wdata,
  input  logic [STRB_W-1:0] cbus_wstrb,
  input  logic              cbus_wvalid,
  output logic              cbus_wready,
  output logic [1:0]        cbus_bresp,
  output logic              cbus_bvalid,
  input  logic              cbus_bready,
  input  logic [ADDR_W-1:0] cbus_araddr,
  input  logic              cbus_arvalid,
  output logic              cbus_arready,
  output logic [DATA_W-1:0] cbus_rdata,
  output logic [1:0]        cbus_rresp,
  output logic              cbus_rvalid,
  input  logic              cbus_rready,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [DATA_W-1:0] wr_data,
  output logic [STRB_W-1:0] wr_strb,
  input  logic              wr_err,
  output logic              rd_en,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_err
);

  wr_state_t wr_state, wr_state_d;
  rd_state_t rd_state, rd_state_d;

  logic              aw_done, aw_done_d;
  logic              w_done, w_done_d;
  logic [IDX_W-1:0]  aw_idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              aw_hs, w_hs, ar_hs;

  // Sub-word address bits carry no meaning for word-wide registers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{cbus_awaddr[OFF_W-1:0], cbus_araddr[OFF_W-1:0]};

  assign aw_hs = cbus_awvalid && cbus_awready;
  assign w_hs  = cbus_wvalid && cbus_wready;
  assign ar_hs = cbus_arvalid && cbus_arready;

  always_comb begin
    wr_state_d = wr_state;
    aw_done_d  = aw_done;
    w_done_d   = w_done;
    case (wr_state)
      W_IDLE: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) wr_state_d = W_EXEC;
      end
      W_EXEC: wr_state_d = W_RESP;
      W_RESP: begin
        if (cbus_bready) begin
          wr_state_d = W_IDLE;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Readies are registered from the next state so they stay low during reset
  // and rise only on the first edge after rstn is released.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state     <= W_IDLE;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      cbus_awready <= 1'b0;
      cbus_wready  <= 1'b0;
      aw_idx_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      cbus_bresp   <= RESP_OKAY;
    end else begin
      wr_state     <= wr_state_d;
      aw_done      <= aw_done_d;
      w_done       <= w_done_d;
      cbus_awready <= (wr_state_d == W_IDLE) && !aw_done_d;
      cbus_wready  <= (wr_state_d == W_IDLE) && !w_done_d;
      if (aw_hs) aw_idx_q <= cbus_awaddr[ADDR_W-1:OFF_W];
      if (w_hs) begin
        wdata_q <= cbus_wdata;
        wstrb_q <= cbus_wstrb;
      end
      if (wr_state == W_EXEC) cbus_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign cbus_bvalid = (wr_state == W_RESP);
  assign wr_en       = (wr_state == W_EXEC);
  assign wr_idx      = aw_idx_q;
  assign wr_data     = wdata_q;
  assign wr_strb     = wstrb_q;

  always_comb begin
    rd_state_d = rd_state;
    case (rd_state)
      R_IDLE: if (ar_hs) rd_state_d = R_RESP;
      R_RESP: if (cbus_rready) rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state     <= R_IDLE;
      cbus_arready <= 1'b0;
      cbus_rdata   <= '0;
      cbus_rresp   <= RESP_OKAY;
    end else begin
      rd_state     <= rd_state_d;
      cbus_arready <= (rd_state_d == R_IDLE);
      if (ar_hs) begin
        cbus_rdata <= rd_data;
        cbus_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign cbus_rvalid = (rd_state == R_RESP);
  assign rd_en       = ar_hs;
  assign rd_idx      = cbus_araddr[ADDR_W-1:OFF_W];

endmodule

// File: rtl/axilite_csr_bank.sv
// AXI4-Lite CSR bank: NUM_RW read-write, NUM_RO read-only and NUM_TRIG
// trigger registers behind an AXI4-Lite slave.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   cbus_*             AXI4-Lite slave channels
//   csr_rw/csr_rw_wr   RW register contents (flattened) and write pulses
//   csr_ro             RO values, sampled on the read handshake
//   csr_trig           one-cycle trigger pulses
//   csr_trig_stat      status returned when a trigger register is read
module axilite_csr_bank
  import axilite_pkg::*;
#(
  parameter  int unsigned DATA_W   = 32,
  parameter  int unsigned ADDR_W   = 8,
  parameter  int unsigned NUM_RW   = 4,
  parameter  int unsigned NUM_RO   = 2,
  parameter  int unsigned NUM_TRIG = 1,
  localparam int unsigned STRB_W   = DATA_W / 8,
  localparam int unsigned IDX_W    = ADDR_W - $clog2(STRB_W)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [ADDR_W-1:0]          cbus_awaddr,
  input  logic                       cbus_awvalid,
  output logic                       cbus_awready,
  input  logic [DATA_W-1:0]          cbus_wdata,
  input  logic [STRB_W-1:0]          cbus_wstrb,
  input  logic                       cbus_wvalid,
  output logic                       cbus_wready,
  output logic [1:0]                 cbus_bresp,
  output logic                       cbus_bvalid,
  input  logic                       cbus_bready,
  input  logic [ADDR_W-1:0]          cbus_araddr,
  input  logic                       cbus_arvalid,
  output logic                       cbus_arready,
  output logic [DATA_W-1:0]          cbus_rdata,
  output logic [1:0]                 cbus_rresp,
  output logic                       cbus_rvalid,
  input  logic                       cbus_rready,
  output logic [NUM_RW*DATA_W-1:0]   csr_rw,
  output logic [NUM_RW-1:0]          csr_rw_wr,
  input  logic [NUM_RO*DATA_W-1:0]   csr_ro,
  output logic [NUM_TRIG*DATA_W-1:0] csr_trig,
  input  logic [NUM_TRIG*DATA_W-1:0] csr_trig_stat
);

  logic              wr_en, wr_err, rd_en, rd_err;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [DATA_W-1:0] wr_data, rd_data, strb_mask;
  logic [STRB_W-1:0] wr_strb;
  decode_t           wr_dec, rd_dec;

  logic [NUM_RW-1:0][DATA_W-1:0] rw_q;

  axilite_slave_if #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_if (
    .clk          (clk),
    .rstn         (rstn),
    .cbus_awaddr  (cbus_awaddr),
    .cbus_awvalid (cbus_awvalid),
    .cbus_awready (cbus_awready),
    .cbus_wdata   (cbus_wdata),
    .cbus_wstrb   (cbus_wstrb),
    .cbus_wvalid  (cbus_wvalid),
    .cbus_wready  (cbus_wready),
    .cbus_bresp   (cbus_bresp),
    .cbus_bvalid  (cbus_bvalid),
    .cbus_bready  (cbus_bready),
    .cbus_araddr  (cbus_araddr),
    .cbus_arvalid (cbus_arvalid),
    .cbus_arready (cbus_arready),
    .cbus_rdata   (cbus_rdata),
    .cbus_rresp   (cbus_rresp),
    .cbus_rvalid  (cbus_rvalid),
    .cbus_rready  (cbus_rready),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data),
    .wr_strb      (wr_strb),
    .wr_err       (wr_err),
    .rd_en        (rd_en),
    .rd_idx       (rd_idx),
    .rd_data      (rd_data),
    .rd_err       (rd_err)
  );

  assign wr_dec = decode_word(32'(wr_idx), NUM_RW, NUM_RO, NUM_TRIG);
  assign rd_dec = decode_word(32'(rd_idx), NUM_RW, NUM_RO, NUM_TRIG);
  assign wr_err = !(wr_dec.region == REG_RW || wr_dec.region == REG_TRIG);

  always_comb begin
    strb_mask = '0;
    for (int unsigned b = 0; b < STRB_W; b++)
      strb_mask[b*8 +: 8] = {8{wr_strb[b]}};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rw_q <= '0;
    end else if (wr_en && wr_dec.region == REG_RW) begin
      for (int unsigned i = 0; i < NUM_RW; i++)
        if (wr_dec.idx == i) rw_q[i] <= (rw_q[i] & ~strb_mask) | (wr_data & strb_mask);
    end
  end

  assign csr_rw = rw_q;

  // Write-event pulses fire for any write to the register, even with no strobes set.
  always_comb begin
    csr_rw_wr = '0;
    csr_trig  = '0;
    for (int unsigned i = 0; i < NUM_RW; i++)
      csr_rw_wr[i] = wr_en && (wr_dec.region == REG_RW) && (wr_dec.idx == i);
    for (int unsigned t = 0; t < NUM_TRIG; t++)
      if (wr_en && (wr_dec.region == REG_TRIG) && (wr_dec.idx == t))
        csr_trig[t*DATA_W +: DATA_W] = wr_data & strb_mask;
  end

  // rw_q is read before this cycle's write lands, so a colliding read sees the old value.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (rd_en) begin
      case (rd_dec.region)
        REG_RW:
          for (int unsigned i = 0; i < NUM_RW; i++)
            if (rd_dec.idx == i) rd_data = rw_q[i];
        REG_RO:
          for (int unsigned i = 0; i < NUM_RO; i++)
            if (rd_dec.idx == i) rd_data = csr_ro[i*DATA_W +: DATA_W];
        REG_TRIG:
          for (int unsigned i = 0; i < NUM_TRIG; i++)
            if (rd_dec.idx == i) rd_data = csr_trig_stat[i*DATA_W +: DATA_W];
        default: rd_err = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_csr_bank.sv
// Self-checking bench for axilite_csr_bank (default parameters: 4 RW, 2 RO, 1 TRIG, 32-bit).
module tb_axilite_csr_bank;

  logic         clk = 1'b0;
  logic         rstn;
  logic [7:0]   cbus_awaddr, cbus_araddr;
  logic         cbus_awvalid, cbus_awready, cbus_wvalid, cbus_wready;
  logic [31:0]  cbus_wdata, cbus_rdata;
  logic [3:0]   cbus_wstrb;
  logic [1:0]   cbus_bresp, cbus_rresp;
  logic         cbus_bvalid, cbus_bready, cbus_arvalid, cbus_arready;
  logic         cbus_rvalid, cbus_rready;
  logic [127:0] csr_rw;
  logic [3:0]   csr_rw_wr;
  logic [63:0]  csr_ro;
  logic [31:0]  csr_trig, csr_trig_stat;

  axilite_csr_bank #(
    .DATA_W (32), .ADDR_W (8), .NUM_RW (4), .NUM_RO (2), .NUM_TRIG (1)
  ) dut (
    .clk (clk), .rstn (rstn),
    .cbus_awaddr (cbus_awaddr), .cbus_awvalid (cbus_awvalid), .cbus_awready (cbus_awready),
    .cbus_wdata (cbus_wdata), .cbus_wstrb (cbus_wstrb), .cbus_wvalid (cbus_wvalid),
    .cbus_wready (cbus_wready), .cbus_bresp (cbus_bresp), .cbus_bvalid (cbus_bvalid),
    .cbus_bready (cbus_bready), .cbus_araddr (cbus_araddr), .cbus_arvalid (cbus_arvalid),
    .cbus_arready (cbus_arready), .cbus_rdata (cbus_rdata), .cbus_rresp (cbus_rresp),
    .cbus_rvalid (cbus_rvalid), .cbus_rready (cbus_rready),
    .csr_rw (csr_rw), .csr_rw_wr (csr_rw_wr), .csr_ro (csr_ro),
    .csr_trig (csr_trig), .csr_trig_stat (csr_trig_stat)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor
  int          wr_pulses [4];
  int          wr_pulse_cyc [4];
  int          trig_pulses = 0;
  logic [31:0] trig_seen = '0;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (csr_rw_wr[i] === 1'b1) begin
        wr_pulses[i]++;
        wr_pulse_cyc[i] = cyc;
      end
    if (csr_trig !== 32'h0 && !$isunknown(csr_trig)) begin
      trig_pulses++;
      trig_seen = csr_trig;
    end
  end

  // Reference model state
  logic [31:0] rw_m [4];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

  // lead > 0: AW presented lead cycles before W; lead < 0: W first.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead, input int bdelay,
                           output logic [1:0] resp, output int lat);
    int aw_at, w_at, k, hs;
    bit awd, wd;
    aw_at = (lead < 0) ? -lead : 0;
    w_at  = (lead > 0) ? lead : 0;
    k = 0; hs = 0; awd = 0; wd = 0; resp = 2'bxx; lat = -1;
    while (!(awd && wd) && k <= 40) begin
      if (k == aw_at && !awd) begin cbus_awaddr = addr; cbus_awvalid = 1'b1; end
      if (k == w_at && !wd) begin cbus_wdata = data; cbus_wstrb = strb; cbus_wvalid = 1'b1; end
      if (cbus_awvalid && cbus_awready) begin awd = 1; hs = cyc; end
      if (cbus_wvalid && cbus_wready) begin wd = 1; hs = cyc; end
      @(negedge clk);
      if (awd) cbus_awvalid = 1'b0;
      if (wd)  cbus_wvalid  = 1'b0;
      k++;
    end
    chk("wr_handshakes", {awd, wd}, 2'b11);
    if (!(awd && wd)) begin cbus_awvalid = 1'b0; cbus_wvalid = 1'b0; return; end
    k = 0;
    while (!cbus_bvalid && k < 20) begin @(negedge clk); k++; end
    chk("bvalid_seen", cbus_bvalid, 1'b1);
    if (!cbus_bvalid) return;
    lat  = cyc - hs;
    resp = cbus_bresp;
    for (int d = 0; d < bdelay; d++) begin
      @(negedge clk);
      chk("b_hold", {cbus_bvalid, cbus_bresp}, {1'b1, resp});
    end
    cbus_bready = 1'b1;
    @(negedge clk);
    cbus_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, input int rdelay, output logic [31:0] data,
                          output logic [1:0] resp, output int lat, output int hs);
    int k;
    k = 0; data = 'x; resp = 'x; lat = -1; hs = -1;
    cbus_araddr = addr; cbus_arvalid = 1'b1;
    while (!cbus_arready && k < 20) begin @(negedge clk); k++; end
    chk("ar_ready", cbus_arready, 1'b1);
    if (!cbus_arready) begin cbus_arvalid = 1'b0; return; end
    hs = cyc;
    @(negedge clk);
    cbus_arvalid = 1'b0;
    k = 0;
    while (!cbus_rvalid && k < 20) begin @(negedge clk); k++; end
    chk("rvalid_seen", cbus_rvalid, 1'b1);
    if (!cbus_rvalid) return;
    lat = cyc - hs; data = cbus_rdata; resp = cbus_rresp;
    for (int d = 0; d < rdelay; d++) begin
      csr_ro = {$urandom, $urandom};   // must not leak into a held response
      @(negedge clk);
      chk("r_hold", {cbus_rvalid, cbus_rresp, cbus_rdata}, {1'b1, resp, data});
    end
    cbus_rready = 1'b1;
    @(negedge clk);
    cbus_rready = 1'b0;
  endtask

  function automatic logic [127:0] rw_flat();
    return {rw_m[3], rw_m[2], rw_m[1], rw_m[0]};
  endfunction

  task automatic wr_check(input string tag, input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input int bdelay);
    int idx, lat, pt;
    int pw [4];
    logic [1:0] resp, exp_resp;
    logic [31:0] exp_trig;
    logic [127:0] got_d, exp_d;
    idx = int'(addr[7:2]);
    pt = trig_pulses;
    for (int i = 0; i < 4; i++) pw[i] = wr_pulses[i];
    exp_trig = '0;
    exp_d = '0;
    if (idx < 4) begin
      rw_m[idx] = (rw_m[idx] & ~mask_of(strb)) | (data & mask_of(strb));
      exp_d[idx*32 +: 32] = 32'd1;
      exp_resp = 2'b00;
    end else if (idx == 6) begin
      exp_trig = data & mask_of(strb);
      exp_resp = 2'b00;
    end else begin
      exp_resp = 2'b10;
    end
    axi_write(addr, data, strb, lead, bdelay, resp, lat);
    for (int i = 0; i < 4; i++) got_d[i*32 +: 32] = 32'(wr_pulses[i] - pw[i]);
    chk({tag, "_bresp"}, resp, exp_resp);
    chk({tag, "_blat"}, lat, 2);
    chk({tag, "_csr_rw"}, csr_rw, rw_flat());
    chk({tag, "_rw_pulses"}, got_d, exp_d);
    chk({tag, "_trig_pulses"}, trig_pulses - pt, (exp_trig != 0) ? 1 : 0);
    if (exp_trig != 0) chk({tag, "_trig_val"}, trig_seen, exp_trig);
  endtask

  task automatic rd_check(input string tag, input logic [7:0] addr, input int rdelay);
    int idx, lat, hs;
    logic [31:0] exp_data, data;
    logic [1:0] exp_resp, resp;
    idx = int'(addr[7:2]);
    exp_resp = 2'b00;
    if (idx < 4)       exp_data = rw_m[idx];
    else if (idx < 6)  exp_data = csr_ro[(idx-4)*32 +: 32];
    else if (idx == 6) exp_data = csr_trig_stat;
    else begin exp_data = '0; exp_resp = 2'b10; end
    axi_read(addr, rdelay, data, resp, lat, hs);
    chk({tag, "_rdata"}, data, exp_data);
    chk({tag, "_rresp"}, resp, exp_resp);
    chk({tag, "_rlat"}, lat, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d5;
    logic [1:0]  r5a, r5b;
    int          l5a, l5b, hs5, k;
    logic [7:0]  a;

    rstn = 1'b0;
    cbus_awaddr = '0; cbus_awvalid = 0; cbus_wdata = '0; cbus_wstrb = '0; cbus_wvalid = 0;
    cbus_bready = 0; cbus_araddr = '0; cbus_arvalid = 0; cbus_rready = 0;
    csr_ro = '0; csr_trig_stat = '0;
    for (int i = 0; i < 4; i++) begin rw_m[i] = '0; wr_pulses[i] = 0; wr_pulse_cyc[i] = -1; end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_handshake", {cbus_awready, cbus_wready, cbus_arready, cbus_bvalid, cbus_rvalid,
                          cbus_bresp, cbus_rresp}, '0);
    chk("rst_data", {cbus_rdata, csr_rw_wr, csr_trig, csr_rw}, '0);
    rstn = 1'b1;
    @(negedge clk);
    chk("readies_up", {cbus_awready, cbus_wready, cbus_arready}, 3'b111);

    // 1: strobed RW write, AW before W
    wr_check("t1_pre", 8'h04, 32'hFFFF_FFFF, 4'hF, 0, 0);
    wr_check("t1", 8'h04, 32'hA5A5_A5A5, 4'b0011, 1, 0);
    chk("t1_reg1", csr_rw[63:32], 32'hFFFF_A5A5);

    // 2: RO read with backpressure
    csr_ro = {32'hCAFE_F00D, 32'h1234_5678};
    rd_check("t2", 8'h10, 5);

    // 3: trigger write and status read
    wr_check("t3", 8'h18, 32'h5, 4'hF, 0, 1);
    chk("t3_trig_val", trig_seen, 32'h5);
    csr_trig_stat = $urandom;
    rd_check("t3_stat", 8'h18, 0);

    // 4: illegal accesses
    wr_check("t4_ro", 8'h14, $urandom, 4'hF, -1, 0);
    wr_check("t4_unm", 8'h40, $urandom, 4'hF, 2, 0);
    rd_check("t4_unm", 8'h40, 1);
    rd_check("t4_top", 8'hFF, 0);

    // 5: read collides with the write-execute cycle of the same register
    wr_check("t5_pre", 8'h00, 32'h11, 4'hF, 0, 0);
    fork
      axi_write(8'h00, 32'h22, 4'hF, 0, 0, r5a, l5a);
      begin
        @(negedge clk);
        axi_read(8'h00, 0, d5, r5b, l5b, hs5);
      end
    join
    rw_m[0] = 32'h22;
    chk("t5_collide_cycle", hs5, wr_pulse_cyc[0]);
    chk("t5_old_value", d5, 32'h11);
    chk("t5_bresp", r5a, 2'b00);
    rd_check("t5_new", 8'h00, 0);

    // 6: reset while the write response is stalled
    cbus_awaddr = 8'h08; cbus_awvalid = 1'b1;
    cbus_wdata = 32'hDEAD_BEEF; cbus_wstrb = 4'hF; cbus_wvalid = 1'b1;
    @(negedge clk);
    cbus_awvalid = 1'b0; cbus_wvalid = 1'b0;
    k = 0;
    while (!cbus_bvalid && k < 10) begin @(negedge clk); k++; end
    chk("t6_in_resp", cbus_bvalid, 1'b1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_drop", {cbus_bvalid, cbus_awready, cbus_wready, cbus_arready, cbus_rvalid}, '0);
    chk("t6_rst_regs", csr_rw, '0);
    for (int i = 0; i < 4; i++) rw_m[i] = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("t6_readies", {cbus_awready, cbus_wready, cbus_arready, cbus_bvalid}, 4'b1110);
    for (int i = 0; i < 4; i++) rd_check("t6_zero", 8'(i * 4), 0);
    wr_check("t6_after", 8'h0C, 32'h0BAD_CAFE, 4'hF, -1, 0);
    rd_check("t6_after", 8'h0C, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      csr_ro = {$urandom, $urandom};
      csr_trig_stat = $urandom;
      a = ($urandom_range(0, 9) == 0) ? 8'($urandom) :
          8'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        wr_check("rnd_wr", a, $urandom, 4'($urandom), $urandom_range(0, 4) - 2,
                 $urandom_range(0, 2));
      else
        rd_check("rnd_rd", a, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
